// File: rtl/char_mem_pkg.sv
// Shared widths, grid geometry, FSM state encoding and the write-cell record
// used by the character-memory write arbiter.
package char_mem_pkg;

    localparam int X_W      = 7;
    localparam int Y_W      = 6;
    localparam int ASCII_W  = 7;
    localparam int COLOUR_W = 6;

    localparam int COLS_L = 80;
    localparam int ROWS_L = 60;
    localparam int COLS_S = 40;
    localparam int ROWS_S = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [ASCII_W-1:0]  ascii;
        logic [COLOUR_W-1:0] colour;
    } wr_cell_t;

endpackage

// File: rtl/char_write_arbiter_if.sv
// Request/grant, clear-control and memory write-port bundle of the arbiter.
// master = requesters and memory side, slave = the arbiter itself.
interface char_write_arbiter_if;
    import char_mem_pkg::*;

    logic                sL;
    logic                e_req;
    logic [X_W-1:0]      e_x;
    logic [Y_W-1:0]      e_y;
    logic [ASCII_W-1:0]  e_ascii;
    logic [COLOUR_W-1:0] e_colour;
    logic                e_gnt;
    logic                s_req;
    logic [X_W-1:0]      s_x;
    logic [Y_W-1:0]      s_y;
    logic [ASCII_W-1:0]  s_ascii;
    logic [COLOUR_W-1:0] s_colour;
    logic                s_gnt;
    logic                clr_req;
    logic                clr_busy;
    logic                clr_done;
    logic [X_W-1:0]      wrx;
    logic [Y_W-1:0]      wry;
    logic [ASCII_W-1:0]  wascii;
    logic [COLOUR_W-1:0] wcolour;
    logic                wren;

    modport master (
        output sL, e_req, e_x, e_y, e_ascii, e_colour,
        output s_req, s_x, s_y, s_ascii, s_colour, clr_req,
        input  e_gnt, s_gnt, clr_busy, clr_done,
        input  wrx, wry, wascii, wcolour, wren
    );

    modport slave (
        input  sL, e_req, e_x, e_y, e_ascii, e_colour,
        input  s_req, s_x, s_y, s_ascii, s_colour, clr_req,
        output e_gnt, s_gnt, clr_busy, clr_done,
        output wrx, wry, wascii, wcolour, wren
    );

endinterface

// File: rtl/clear_sweeper.sv
// Row-major x/y cell counters for the clear sweep; grid size is latched on start
// so the sweep geometry cannot change once running.
module clear_sweeper
    import char_mem_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start_i,
    input  logic           step_i,
    input  logic           sl_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);

    localparam logic [X_W-1:0] X_MAX_L = X_W'(COLS_L - 1);
    localparam logic [X_W-1:0] X_MAX_S = X_W'(COLS_S - 1);
    localparam logic [Y_W-1:0] Y_MAX_L = Y_W'(ROWS_L - 1);
    localparam logic [Y_W-1:0] Y_MAX_S = Y_W'(ROWS_S - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           large_q, large_d;
    logic [X_W-1:0] x_max_s;
    logic [Y_W-1:0] y_max_s;

    assign x_max_s = large_q ? X_MAX_L : X_MAX_S;
    assign y_max_s = large_q ? Y_MAX_L : Y_MAX_S;
    assign last_o  = (x_q == x_max_s) && (y_q == y_max_s);
    assign x_o     = x_q;
    assign y_o     = y_q;

    // Counter next-state: restart on start, advance one cell per step
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        large_d = large_q;
        if (start_i) begin
            x_d     = {X_W{1'b0}};
            y_d     = {Y_W{1'b0}};
            large_d = sl_i;
        end else if (step_i) begin
            if (x_q == x_max_s) begin
                x_d = {X_W{1'b0}};
                if (y_q == y_max_s) begin
                    y_d = {Y_W{1'b0}};
                end else begin
                    y_d = y_q + Y_W'(1);
                end
            end else begin
                x_d = x_q + X_W'(1);
                y_d = y_q;
            end
        end else begin
            x_d     = x_q;
            y_d     = y_q;
            large_d = large_q;
        end
    end

    // Counter and grid-size registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= {X_W{1'b0}};
            y_q     <= {Y_W{1'b0}};
            large_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            large_q <= large_d;
        end
    end

endmodule

// File: rtl/char_write_arbiter.sv
// Round-robin edit/search write arbiter with a registered write port and an
// optional full-grid clear sweep (enabled by defining CHAR_ARB_CLEAR_EN).
module char_write_arbiter
    import char_mem_pkg::*;
#(
    parameter logic [COLOUR_W-1:0] CLR_COLOUR  = 6'h3F,
    parameter logic [ASCII_W-1:0]  BLANK_ASCII = 7'h20
) (
    input  logic                clk,
    input  logic                reset,
    char_write_arbiter_if.slave bus
);

    localparam wr_cell_t CELL_ZERO = wr_cell_t'({$bits(wr_cell_t){1'b0}});

    arb_state_e     state_q, state_d;
    logic           last_srch_q, last_srch_d;
    logic           e_gnt_q, e_gnt_d;
    logic           s_gnt_q, s_gnt_d;
    logic           pend_vld_q, pend_vld_d;
    wr_cell_t       pend_q, pend_d;
    wr_cell_t       wr_q, wr_d;
    logic           wren_q, wren_d;
    logic           clr_busy_q, clr_busy_d;
    logic           clr_done_q, clr_done_d;

    logic           clr_fire_s;
    logic           arb_ok_s;
    logic           grant_e_s;
    logic           grant_s_s;
    logic           sw_step_s;
    logic           sw_last_s;
    logic [X_W-1:0] sw_x_s;
    logic [Y_W-1:0] sw_y_s;

    assign sw_step_s = (state_q == ST_CLEAR);

`ifdef CHAR_ARB_CLEAR_EN
    assign clr_fire_s = bus.clr_req && (state_q == ST_IDLE);

    clear_sweeper u_sweeper (
        .clk     (clk),
        .reset   (reset),
        .start_i (clr_fire_s),
        .step_i  (sw_step_s),
        .sl_i    (bus.sL),
        .x_o     (sw_x_s),
        .y_o     (sw_y_s),
        .last_o  (sw_last_s)
    );
`else
    logic unused_s;
    assign unused_s   = ^{bus.clr_req, bus.sL, sw_step_s};
    assign clr_fire_s = 1'b0;
    assign sw_x_s     = {X_W{1'b0}};
    assign sw_y_s     = {Y_W{1'b0}};
    assign sw_last_s  = 1'b0;
`endif

    // A clear request takes the cycle; the requester not granted last wins a tie
    assign arb_ok_s  = (state_q == ST_IDLE) && !clr_fire_s;
    assign grant_e_s = arb_ok_s && bus.e_req && (!bus.s_req || last_srch_q);
    assign grant_s_s = arb_ok_s && bus.s_req && (!bus.e_req || !last_srch_q);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_fire_s) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (sw_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: grants, captured cell, write-port mux and clear status
    always_comb begin
        last_srch_d = last_srch_q;
        e_gnt_d     = grant_e_s;
        s_gnt_d     = grant_s_s;
        pend_d      = pend_q;
        pend_vld_d  = 1'b0;
        wr_d        = wr_q;
        wren_d      = 1'b0;
        if (grant_e_s) begin
            pend_d      = '{x: bus.e_x, y: bus.e_y, ascii: bus.e_ascii, colour: bus.e_colour};
            pend_vld_d  = 1'b1;
            last_srch_d = 1'b0;
        end else if (grant_s_s) begin
            pend_d      = '{x: bus.s_x, y: bus.s_y, ascii: bus.s_ascii, colour: bus.s_colour};
            pend_vld_d  = 1'b1;
            last_srch_d = 1'b1;
        end else begin
            pend_d      = pend_q;
            pend_vld_d  = 1'b0;
            last_srch_d = last_srch_q;
        end
        // Grants never coexist with CLEAR, so a pending cell never collides with a sweep write
        if (state_q == ST_CLEAR) begin
            wren_d = 1'b1;
            wr_d   = '{x: sw_x_s, y: sw_y_s, ascii: BLANK_ASCII, colour: CLR_COLOUR};
        end else if (pend_vld_q) begin
            wren_d = 1'b1;
            wr_d   = pend_q;
        end else begin
            wren_d = 1'b0;
            wr_d   = wr_q;
        end
        clr_busy_d = (state_d == ST_CLEAR);
        clr_done_d = (state_d == ST_DONE);
    end

    // Registered outputs and arbitration state
    always_ff @(posedge clk) begin
        if (reset) begin
            last_srch_q <= 1'b1;
            e_gnt_q     <= 1'b0;
            s_gnt_q     <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_q      <= CELL_ZERO;
            wr_q        <= CELL_ZERO;
            wren_q      <= 1'b0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            last_srch_q <= last_srch_d;
            e_gnt_q     <= e_gnt_d;
            s_gnt_q     <= s_gnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_q      <= pend_d;
            wr_q        <= wr_d;
            wren_q      <= wren_d;
            clr_busy_q  <= clr_busy_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign bus.e_gnt    = e_gnt_q;
    assign bus.s_gnt    = s_gnt_q;
    assign bus.clr_busy = clr_busy_q;
    assign bus.clr_done = clr_done_q;
    assign bus.wren     = wren_q;
    assign bus.wrx      = wr_q.x;
    assign bus.wry      = wr_q.y;
    assign bus.wascii   = wr_q.ascii;
    assign bus.wcolour  = wr_q.colour;

endmodule

// File: tb/tb_char_write_arbiter.sv
// Directed self-checking bench for char_write_arbiter; clear-sweep scenarios
// run only when CHAR_ARB_CLEAR_EN is defined, otherwise the disabled-clear case runs.
module tb_char_write_arbiter;
    import char_mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    char_write_arbiter_if bus ();

    char_write_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sL = 1'b0;   bus.clr_req = 1'b0;
        bus.e_req = 1'b0; bus.e_x = 7'd0; bus.e_y = 6'd0; bus.e_ascii = 7'd0; bus.e_colour = 6'd0;
        bus.s_req = 1'b0; bus.s_x = 7'd0; bus.s_y = 6'd0; bus.s_ascii = 7'd0; bus.s_colour = 6'd0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.e_req = 1'b1; bus.s_req = 1'b1; bus.clr_req = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %0b expected 0", bus.wren); end
        n_checks++; if ({bus.wrx, bus.wry, bus.wascii, bus.wcolour} !== 26'd0) begin n_fail++; $display("FAIL reset_fields: got %0h expected 0", {bus.wrx, bus.wry, bus.wascii, bus.wcolour}); end
        n_checks++; if ({bus.e_gnt, bus.s_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %0b expected 00", {bus.e_gnt, bus.s_gnt}); end
        n_checks++; if ({bus.clr_busy, bus.clr_done} !== 2'b00) begin n_fail++; $display("FAIL reset_clr: got %0b expected 00", {bus.clr_busy, bus.clr_done}); end
        idle_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_edit();
        bus.e_req = 1'b1; bus.e_x = 7'd5; bus.e_y = 6'd3; bus.e_ascii = 7'h41; bus.e_colour = 6'h0C;
        tick();
        n_checks++; if ({bus.e_gnt, bus.s_gnt} !== 2'b10) begin n_fail++; $display("FAIL edit_gnt: got %0b expected 10", {bus.e_gnt, bus.s_gnt}); end
        n_checks++; if (bus.wren !== 1'b0) begin n_fail++; $display("FAIL edit_early_wren: got %0b expected 0", bus.wren); end
        bus.e_req = 1'b0;
        tick();
        n_checks++; if (bus.wren !== 1'b1) begin n_fail++; $display("FAIL edit_wren: got %0b expected 1", bus.wren); end
        n_checks++; if ({bus.wrx, bus.wry, bus.wascii, bus.wcolour} !== {7'd5, 6'd3, 7'h41, 6'h0C}) begin n_fail++; $display("FAIL edit_data: got %0h expected %0h", {bus.wrx, bus.wry, bus.wascii, bus.wcolour}, {7'd5, 6'd3, 7'h41, 6'h0C}); end
        n_checks++; if (bus.e_gnt !== 1'b0) begin n_fail++; $display("FAIL edit_gnt_pulse: got %0b expected 0", bus.e_gnt); end
        tick();
        n_checks++; if (bus.wren !== 1'b0) begin n_fail++; $display("FAIL edit_idle_wren: got %0b expected 0", bus.wren); end
        n_checks++; if ({bus.wrx, bus.wry} !== {7'd5, 6'd3}) begin n_fail++; $display("FAIL edit_hold: got %0h expected %0h", {bus.wrx, bus.wry}, {7'd5, 6'd3}); end
    endtask

    task automatic test_round_robin();
        logic exp_e;
        logic prev_e;
        apply_reset();
        bus.e_x = 7'd10; bus.e_y = 6'd1; bus.e_ascii = 7'h45; bus.e_colour = 6'h01;
        bus.s_x = 7'd20; bus.s_y = 6'd2; bus.s_ascii = 7'h53; bus.s_colour = 6'h02;
        bus.e_req = 1'b1; bus.s_req = 1'b1;
        prev_e = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_e = (i % 2 == 0);
            n_checks++; if ({bus.e_gnt, bus.s_gnt} !== {exp_e, !exp_e}) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %0b expected %0b", i, {bus.e_gnt, bus.s_gnt}, {exp_e, !exp_e}); end
            if (i > 0) begin
                n_checks++; if ({bus.wren, bus.wrx} !== {1'b1, (prev_e ? 7'd10 : 7'd20)}) begin n_fail++; $display("FAIL rr_write[%0d]: got %0h expected %0h", i, {bus.wren, bus.wrx}, {1'b1, (prev_e ? 7'd10 : 7'd20)}); end
            end
            prev_e = exp_e;
        end
        bus.e_req = 1'b0; bus.s_req = 1'b0;
        tick();
        n_checks++; if ({bus.wren, bus.wrx, bus.wascii} !== {1'b1, 7'd20, 7'h53}) begin n_fail++; $display("FAIL rr_last_write: got %0h expected %0h", {bus.wren, bus.wrx, bus.wascii}, {1'b1, 7'd20, 7'h53}); end
        tick();
        n_checks++; if (bus.wren !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %0b expected 0", bus.wren); end
    endtask

    task automatic test_search_only();
        bus.s_req = 1'b1; bus.s_x = 7'd33; bus.s_y = 6'd44; bus.s_ascii = 7'h7A; bus.s_colour = 6'h2A;
        tick();
        n_checks++; if ({bus.e_gnt, bus.s_gnt} !== 2'b01) begin n_fail++; $display("FAIL search_gnt: got %0b expected 01", {bus.e_gnt, bus.s_gnt}); end
        bus.s_req = 1'b0;
        tick();
        n_checks++; if ({bus.wren, bus.wrx, bus.wry, bus.wascii, bus.wcolour} !== {1'b1, 7'd33, 6'd44, 7'h7A, 6'h2A}) begin n_fail++; $display("FAIL search_data: got %0h expected %0h", {bus.wren, bus.wrx, bus.wry, bus.wascii, bus.wcolour}, {1'b1, 7'd33, 6'd44, 7'h7A, 6'h2A}); end
        // Search granted last, so a tie now goes to edit
        bus.e_req = 1'b1; bus.s_req = 1'b1;
        tick();
        n_checks++; if ({bus.e_gnt, bus.s_gnt} !== 2'b10) begin n_fail++; $display("FAIL tie_after_search: got %0b expected 10", {bus.e_gnt, bus.s_gnt}); end
        idle_inputs();
        tick();
        tick();
    endtask

`ifdef CHAR_ARB_CLEAR_EN
    task automatic test_clear_small();
        int busy_cnt, wr_cnt, bad, done_cnt, gnt_tick;
        logic [6:0] ex, lx;
        logic [5:0] ey, ly;
        bus.sL = 1'b0; bus.clr_req = 1'b1;
        bus.e_req = 1'b1; bus.e_x = 7'd7; bus.e_y = 6'd9; bus.e_ascii = 7'h55; bus.e_colour = 6'h15;
        tick();
        n_checks++; if ({bus.clr_busy, bus.e_gnt, bus.s_gnt} !== 3'b100) begin n_fail++; $display("FAIL clr_wins_tie: got %0b expected 100", {bus.clr_busy, bus.e_gnt, bus.s_gnt}); end
        bus.clr_req = 1'b0;
        busy_cnt = 1; wr_cnt = 0; bad = 0; done_cnt = 0; gnt_tick = -1;
        ex = 7'd0; ey = 6'd0; lx = 7'd0; ly = 6'd0;
        for (int t = 1; t <= 1215; t++) begin
            tick();
            if (bus.clr_busy) busy_cnt++;
            if (bus.clr_done) done_cnt++;
            if (gnt_tick > 0 && t == gnt_tick + 1) begin
                n_checks++; if ({bus.wren, bus.wrx, bus.wry, bus.wascii, bus.wcolour} !== {1'b1, 7'd7, 6'd9, 7'h55, 6'h15}) begin n_fail++; $display("FAIL clr_wait_write: got %0h expected %0h", {bus.wren, bus.wrx, bus.wry, bus.wascii, bus.wcolour}, {1'b1, 7'd7, 6'd9, 7'h55, 6'h15}); end
            end
            if ((bus.e_gnt || bus.s_gnt) && gnt_tick < 0) begin
                gnt_tick = t;
                bus.e_req = 1'b0;
            end
            if (bus.wren && gnt_tick < 0) begin
                wr_cnt++;
                if (bus.wrx !== ex || bus.wry !== ey || bus.wascii !== 7'h20 || bus.wcolour !== 6'h3F) bad++;
                lx = bus.wrx; ly = bus.wry;
                if (ex == 7'd39) begin
                    ex = 7'd0;
                    ey = (ey == 6'd29) ? 6'd0 : ey + 6'd1;
                end else begin
                    ex = ex + 7'd1;
                end
            end
        end
        n_checks++; if (busy_cnt !== 1200) begin n_fail++; $display("FAIL small_busy_cycles: got %0d expected 1200", busy_cnt); end
        n_checks++; if (wr_cnt !== 1200) begin n_fail++; $display("FAIL small_writes: got %0d expected 1200", wr_cnt); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL small_cell_order: got %0d bad cells expected 0", bad); end
        n_checks++; if ({lx, ly} !== {7'd39, 6'd29}) begin n_fail++; $display("FAIL small_last_cell: got %0h expected %0h", {lx, ly}, {7'd39, 6'd29}); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL small_done_pulses: got %0d expected 1", done_cnt); end
        n_checks++; if (gnt_tick !== 1202) begin n_fail++; $display("FAIL small_wait_gnt_tick: got %0d expected 1202", gnt_tick); end
        idle_inputs();
        tick();
    endtask

    task automatic test_clear_large();
        int wr_cnt, bad, done_cnt, done_tick;
        logic [6:0] ex, lx;
        logic [5:0] ey, ly;
        bus.sL = 1'b1; bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        wr_cnt = 0; bad = 0; done_cnt = 0; done_tick = -1;
        ex = 7'd0; ey = 6'd0; lx = 7'd0; ly = 6'd0;
        for (int t = 1; t <= 4830; t++) begin
            tick();
            if (t == 100) begin bus.sL = 1'b0; bus.clr_req = 1'b1; end
            if (t == 101) bus.clr_req = 1'b0;
            if (bus.clr_done) begin done_cnt++; done_tick = t; end
            if (bus.wren) begin
                wr_cnt++;
                if (bus.wrx !== ex || bus.wry !== ey || bus.wascii !== 7'h20 || bus.wcolour !== 6'h3F) bad++;
                lx = bus.wrx; ly = bus.wry;
                if (ex == 7'd79) begin
                    ex = 7'd0;
                    ey = (ey == 6'd59) ? 6'd0 : ey + 6'd1;
                end else begin
                    ex = ex + 7'd1;
                end
            end
        end
        n_checks++; if (wr_cnt !== 4800) begin n_fail++; $display("FAIL large_writes: got %0d expected 4800", wr_cnt); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL large_cell_order: got %0d bad cells expected 0", bad); end
        n_checks++; if ({lx, ly} !== {7'd79, 6'd59}) begin n_fail++; $display("FAIL large_last_cell: got %0h expected %0h", {lx, ly}, {7'd79, 6'd59}); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL large_done_pulses: got %0d expected 1", done_cnt); end
        n_checks++; if (done_tick !== 4800) begin n_fail++; $display("FAIL large_done_tick: got %0d expected 4800", done_tick); end
        idle_inputs();
    endtask

    task automatic test_reset_midsweep();
        int done_cnt;
        bus.sL = 1'b0; bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int t = 1; t <= 50; t++) tick();
        bus.e_req = 1'b1; bus.e_x = 7'd3; bus.e_y = 6'd4; bus.e_ascii = 7'h61; bus.e_colour = 6'h01;
        reset = 1'b1;
        tick();
        n_checks++; if ({bus.wren, bus.wrx, bus.wry, bus.wascii, bus.wcolour} !== 27'd0) begin n_fail++; $display("FAIL midsweep_reset_write: got %0h expected 0", {bus.wren, bus.wrx, bus.wry, bus.wascii, bus.wcolour}); end
        n_checks++; if ({bus.e_gnt, bus.s_gnt, bus.clr_busy, bus.clr_done} !== 4'b0000) begin n_fail++; $display("FAIL midsweep_reset_ctrl: got %0b expected 0000", {bus.e_gnt, bus.s_gnt, bus.clr_busy, bus.clr_done}); end
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if ({bus.e_gnt, bus.clr_busy, bus.clr_done} !== 3'b100) begin n_fail++; $display("FAIL midsweep_after_gnt: got %0b expected 100", {bus.e_gnt, bus.clr_busy, bus.clr_done}); end
        bus.e_req = 1'b0;
        tick();
        n_checks++; if ({bus.wren, bus.wrx, bus.wry} !== {1'b1, 7'd3, 6'd4}) begin n_fail++; $display("FAIL midsweep_after_write: got %0h expected %0h", {bus.wren, bus.wrx, bus.wry}, {1'b1, 7'd3, 6'd4}); end
        done_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (bus.clr_done || bus.clr_busy) done_cnt++;
        end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL midsweep_no_done: got %0d expected 0", done_cnt); end
        idle_inputs();
    endtask
`else
    task automatic test_no_clear();
        int busy_cnt;
        bus.sL = 1'b1; bus.clr_req = 1'b1;
        bus.e_req = 1'b1; bus.e_x = 7'd12; bus.e_y = 6'd34; bus.e_ascii = 7'h2A; bus.e_colour = 6'h33;
        tick();
        n_checks++; if ({bus.e_gnt, bus.clr_busy} !== 2'b10) begin n_fail++; $display("FAIL noclr_gnt: got %0b expected 10", {bus.e_gnt, bus.clr_busy}); end
        bus.clr_req = 1'b0; bus.e_req = 1'b0;
        tick();
        n_checks++; if ({bus.wren, bus.wrx, bus.wry, bus.wascii, bus.wcolour} !== {1'b1, 7'd12, 6'd34, 7'h2A, 6'h33}) begin n_fail++; $display("FAIL noclr_write: got %0h expected %0h", {bus.wren, bus.wrx, bus.wry, bus.wascii, bus.wcolour}, {1'b1, 7'd12, 6'd34, 7'h2A, 6'h33}); end
        busy_cnt = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (bus.clr_busy || bus.clr_done || bus.wren) busy_cnt++;
        end
        n_checks++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL noclr_idle: got %0d active cycles expected 0", busy_cnt); end
        idle_inputs();
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_edit();
        test_round_robin();
        test_search_only();
`ifdef CHAR_ARB_CLEAR_EN
        test_clear_small();
        test_clear_large();
        test_reset_midsweep();
`else
        test_no_clear();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
